// File: rtl/fft_sample_loader_if.sv
// Byte-stream in / word-write out bundle for the FFT sample loader.
// The slave modport is the loader's view; the master modport is the view of
// whatever drives the byte stream and consumes the store writes.
interface fft_sample_loader_if #(
  parameter int N      = 16,
  parameter int ADDR_W = 2
);
  logic              i_start;
  logic [7:0]        i_byte;
  logic              i_byte_valid;
  logic              o_byte_ready;
  logic [N-1:0]      o_word;
  logic              o_write_enable;
  logic [ADDR_W-1:0] o_address;
  logic              o_busy;
  logic              o_frame_done;
  logic              i_frame_ack;

  modport slave (
    input  i_start, i_byte, i_byte_valid, i_frame_ack,
    output o_byte_ready, o_word, o_write_enable, o_address, o_busy, o_frame_done
  );

  modport master (
    output i_start, i_byte, i_byte_valid, i_frame_ack,
    input  o_byte_ready, o_word, o_write_enable, o_address, o_busy, o_frame_done
  );
endinterface

// File: rtl/fft_sample_loader.sv
// Feeds the FFT sample store: packs a low-byte-first byte stream into N-bit
// words, writes them to slots 0..WORDS-1 in order, then flags the frame and
// waits for the consumer's acknowledge before accepting another start.
module fft_sample_loader #(
  parameter int N      = 16,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fft_sample_loader_if.slave bus
);
  localparam int BPW = N / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     byte_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic [N-1:0]      asm_word;
  logic [N-1:0]      asm_next;
  logic              xfer;

  // ready is only ever high in COLLECT, so this is the accepted-byte strobe
  assign xfer = bus.i_byte_valid && bus.o_byte_ready;

  // Assembler with the incoming byte dropped into its lane
  always_comb begin
    asm_next = asm_word;
    asm_next[8*byte_cnt +: 8] = bus.i_byte;
  end

  // Control FSM; every output is a register updated alongside the state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state              <= IDLE;
      byte_cnt           <= '0;
      word_idx           <= '0;
      asm_word           <= '0;
      bus.o_word         <= '0;
      bus.o_address      <= '0;
      bus.o_write_enable <= 1'b0;
      bus.o_byte_ready   <= 1'b0;
      bus.o_busy         <= 1'b0;
      bus.o_frame_done   <= 1'b0;
    end else begin
      bus.o_write_enable <= 1'b0;
      bus.o_frame_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            state            <= COLLECT;
            byte_cnt         <= '0;
            word_idx         <= '0;
            asm_word         <= '0;
            bus.o_byte_ready <= 1'b1;
            bus.o_busy       <= 1'b1;
          end
        end
        COLLECT: begin
          if (xfer) begin
            asm_word <= asm_next;
            if (byte_cnt == CW'(BPW - 1)) begin
              // Last byte of the word: present it to the store next cycle
              state              <= WRITE;
              byte_cnt           <= '0;
              bus.o_byte_ready   <= 1'b0;
              bus.o_write_enable <= 1'b1;
              bus.o_address      <= word_idx;
              bus.o_word         <= asm_next;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (word_idx == ADDR_W'(WORDS - 1)) begin
            state            <= DONE;
            bus.o_busy       <= 1'b0;
            bus.o_frame_done <= 1'b1;
          end else begin
            state            <= COLLECT;
            word_idx         <= word_idx + 1'b1;
            bus.o_byte_ready <= 1'b1;
          end
        end
        DONE: begin
          if (bus.i_frame_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader: inputs change on the falling edge,
// a monitor samples 2 ns later and logs store writes, pulses and transfers.
module tb_fft_sample_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_sample_loader_if #(.N(16), .ADDR_W(2)) bus ();

  fft_sample_loader #(.N(16), .WORDS(4), .ADDR_W(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Monitor state
  logic [1:0]  wr_addr[$];
  logic [15:0] wr_word[$];
  logic [15:0] store[4];
  int fd_cnt = 0;
  int xfer_cnt = 0;
  int ready_bad = 0;

  logic [7:0] frame_bytes[8];
  int gaps[8];

  // Log everything the loader does, sampled mid-low-phase
  always begin
    @(negedge clk);
    #2;
    if (bus.o_write_enable) begin
      wr_addr.push_back(bus.o_address);
      wr_word.push_back(bus.o_word);
      store[bus.o_address] = bus.o_word;
    end
    if (bus.o_frame_done) fd_cnt++;
    if (bus.i_byte_valid && bus.o_byte_ready) xfer_cnt++;
    if (bus.o_busy && (bus.o_byte_ready == bus.o_write_enable)) ready_bad++;
    if (!bus.o_busy && bus.o_byte_ready) ready_bad++;
  end

  task clear_log();
    wr_addr.delete();
    wr_word.delete();
    fd_cnt = 0;
    xfer_cnt = 0;
    ready_bad = 0;
  endtask

  task pulse_start();
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task pulse_ack();
    bus.i_frame_ack = 1'b1;
    @(negedge clk);
    bus.i_frame_ack = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; returns at the falling edge
  // following the handshake
  task send_byte(input logic [7:0] b, input int gap);
    int tmo;
    for (int g = 0; g < gap; g++) begin
      bus.i_byte_valid = 1'b0;
      @(negedge clk);
    end
    bus.i_byte = b;
    bus.i_byte_valid = 1'b1;
    tmo = 0;
    while (!bus.o_byte_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 50) begin
      n_vec++; n_bad++;
      $display("FAIL send_byte: ready timeout for byte %h", b);
    end
    @(negedge clk);
    bus.i_byte_valid = 1'b0;
  endtask

  task send_frame();
    for (int i = 0; i < 8; i++) send_byte(frame_bytes[i], gaps[i]);
  endtask

  task wait_done();
    int tmo;
    tmo = 0;
    while (!bus.o_frame_done && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    n_vec++;
    if (tmo >= 100) begin
      n_bad++;
      $display("FAIL wait_done: frame_done never seen, got 0 expected 1");
    end
  endtask

  task set_frame_a();
    frame_bytes = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
  endtask

  task set_frame_b();
    frame_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  endtask

  task check_writes(input string name, input logic [15:0] w0, input logic [15:0] w1,
                    input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] exp_w[4];
    exp_w = '{w0, w1, w2, w3};
    n_vec++;
    if (wr_word.size() !== 4) begin
      n_bad++;
      $display("FAIL %s write count: got %0d expected 4", name, wr_word.size());
    end
    for (int i = 0; i < 4 && i < wr_word.size(); i++) begin
      n_vec++;
      if (wr_addr[i] !== 2'(i) || wr_word[i] !== exp_w[i]) begin
        n_bad++;
        $display("FAIL %s write %0d: got %0d:%h expected %0d:%h",
                 name, i, wr_addr[i], wr_word[i], i, exp_w[i]);
      end
    end
    n_vec++;
    if (fd_cnt !== 1) begin
      n_bad++;
      $display("FAIL %s frame_done pulses: got %0d expected 1", name, fd_cnt);
    end
    n_vec++;
    if (xfer_cnt !== 8) begin
      n_bad++;
      $display("FAIL %s transfers: got %0d expected 8", name, xfer_cnt);
    end
    n_vec++;
    if (ready_bad !== 0) begin
      n_bad++;
      $display("FAIL %s ready outside COLLECT: got %0d bad cycles expected 0", name, ready_bad);
    end
  endtask

  task test_reset();
    bus.i_start = 1'b0;
    bus.i_byte = 8'h00;
    bus.i_byte_valid = 1'b0;
    bus.i_frame_ack = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.o_word, bus.o_address, bus.o_write_enable, bus.o_byte_ready,
         bus.o_busy, bus.o_frame_done} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset outputs: got word=%h addr=%0d we=%b rdy=%b busy=%b fd=%b expected all 0",
               bus.o_word, bus.o_address, bus.o_write_enable, bus.o_byte_ready,
               bus.o_busy, bus.o_frame_done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task test_idle_valid();
    int bad;
    clear_log();
    bad = 0;
    bus.i_byte = 8'hA5;
    bus.i_byte_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.o_byte_ready || bus.o_busy) bad++;
    end
    bus.i_byte_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL idle_valid ready/busy: got %0d bad cycles expected 0", bad);
    end
    n_vec++;
    if (xfer_cnt !== 0 || wr_word.size() !== 0) begin
      n_bad++;
      $display("FAIL idle_valid activity: got %0d transfers %0d writes expected 0 0",
               xfer_cnt, wr_word.size());
    end
  endtask

  task test_back_to_back();
    clear_log();
    set_frame_a();
    gaps = '{0, 0, 0, 0, 0, 0, 0, 0};
    pulse_start();
    send_frame();
    // strobe lands the cycle after the last byte's handshake
    n_vec++;
    if (bus.o_write_enable !== 1'b1 || bus.o_address !== 2'd3) begin
      n_bad++;
      $display("FAIL b2b last strobe latency: got we=%b addr=%0d expected we=1 addr=3",
               bus.o_write_enable, bus.o_address);
    end
    @(negedge clk);
    n_vec++;
    if (bus.o_frame_done !== 1'b1 || bus.o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b frame_done latency: got fd=%b busy=%b expected fd=1 busy=0",
               bus.o_frame_done, bus.o_busy);
    end
    @(negedge clk);
    n_vec++;
    if (bus.o_frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b frame_done width: got %b expected 0", bus.o_frame_done);
    end
    check_writes("b2b", 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    pulse_ack();
  endtask

  task test_gaps();
    clear_log();
    set_frame_a();
    gaps = '{1, 3, 0, 2, 3, 0, 1, 2};
    pulse_start();
    send_frame();
    wait_done();
    @(negedge clk);
    check_writes("gaps", 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    pulse_ack();
  endtask

  task test_done_hold();
    int bad;
    clear_log();
    set_frame_a();
    gaps = '{0, 0, 0, 0, 0, 0, 0, 0};
    pulse_start();
    send_frame();
    wait_done();
    bad = 0;
    bus.i_byte = 8'h55;
    bus.i_byte_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_byte_ready || bus.o_write_enable || bus.o_busy) bad++;
    end
    bus.i_byte_valid = 1'b0;
    n_vec++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL done_hold outputs: got %0d bad cycles expected 0", bad);
    end
    check_writes("done_hold", 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    pulse_ack();
    clear_log();
    set_frame_b();
    pulse_start();
    send_frame();
    wait_done();
    @(negedge clk);
    check_writes("second_frame", 16'h2211, 16'h4433, 16'h6655, 16'h8877);
    pulse_ack();
  endtask

  task test_start_ignored();
    clear_log();
    set_frame_a();
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(frame_bytes[i], 0);
    pulse_start();
    for (int i = 3; i < 8; i++) send_byte(frame_bytes[i], 0);
    wait_done();
    @(negedge clk);
    check_writes("start_ignored", 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    pulse_ack();
  endtask

  task test_reset_mid();
    clear_log();
    store = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA};
    set_frame_a();
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(frame_bytes[i], 0);
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.o_word, bus.o_address, bus.o_write_enable, bus.o_byte_ready,
         bus.o_busy, bus.o_frame_done} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_mid async clear: got word=%h addr=%0d we=%b rdy=%b busy=%b fd=%b expected all 0",
               bus.o_word, bus.o_address, bus.o_write_enable, bus.o_byte_ready,
               bus.o_busy, bus.o_frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (store[0] !== 16'h1234 || store[1] !== 16'h5678 || store[2] !== 16'hAAAA ||
        wr_word.size() !== 2) begin
      n_bad++;
      $display("FAIL reset_mid store: got %h %h %h (%0d writes) expected 1234 5678 aaaa (2 writes)",
               store[0], store[1], store[2], wr_word.size());
    end
    clear_log();
    set_frame_b();
    pulse_start();
    send_frame();
    wait_done();
    @(negedge clk);
    check_writes("after_reset", 16'h2211, 16'h4433, 16'h6655, 16'h8877);
    pulse_ack();
  endtask

  initial begin
    test_reset();
    test_idle_valid();
    test_back_to_back();
    test_gaps();
    test_done_hold();
    test_start_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
